// File: rtl/seq_ctrl.sv
// seq_ctrl: vector sequencer that walks three RAM vectors element by element.
// For each element k it reads A[a_base+k] and B[b_base+k] through a synchronous
// read port. It presents both words to an external combinational ALU, then
// writes the ALU result to D[d_base+k]. Each element takes four cycles:
// RD_A, RD_B, CAP_B, WR. A one-cycle DONE state follows the last element.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   start_i                 command strobe, only honoured in IDLE
//   op_i                    ALU opcode latched with the command
//   a_base_i/b_base_i/d_base_i  vector base addresses (modulo 2^ADDR_W)
//   count_i                 number of elements (0 means an immediate DONE)
//   busy_o, done_o          command in progress / one-cycle completion pulse
//   r_en_o, r_addr_o, r_data_i   RAM read port (data valid one cycle after r_en)
//   alu_a_o, alu_b_o, alu_op_o, alu_res_i   external ALU hookup
//   w_en_o, w_addr_o, w_data_o   RAM write port
module seq_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [4:0]        op_i,
  input  logic [ADDR_W-1:0] a_base_i,
  input  logic [ADDR_W-1:0] b_base_i,
  input  logic [ADDR_W-1:0] d_base_i,
  input  logic [ADDR_W-1:0] count_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              r_en_o,
  output logic [ADDR_W-1:0] r_addr_o,
  input  logic [DATA_W-1:0] r_data_i,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic [4:0]        alu_op_o,
  input  logic [DATA_W-1:0] alu_res_i,
  output logic              w_en_o,
  output logic [ADDR_W-1:0] w_addr_o,
  output logic [DATA_W-1:0] w_data_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD_A = 3'd1;
  localparam logic [2:0] S_RD_B = 3'd2;
  localparam logic [2:0] S_CAP_B = 3'd3;
  localparam logic [2:0] S_WR = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [4:0]        opLatch_q, opLatch_d;
  logic [ADDR_W-1:0] aBase_q, aBase_d;
  logic [ADDR_W-1:0] bBase_q, bBase_d;
  logic [ADDR_W-1:0] dBase_q, dBase_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] aReg_q, aReg_d;
  logic [DATA_W-1:0] bReg_q, bReg_d;

  // Next-state logic. The read issued in RD_A returns during RD_B, and the
  // read issued in RD_B returns during CAP_B, so each capture happens one
  // state after its read. The write in WR always lands before the next RD_A
  // read, which gives in-place vectors plain sequential-loop behaviour.
  always_comb begin
    state_d   = state_q;
    opLatch_d = opLatch_q;
    aBase_d   = aBase_q;
    bBase_d   = bBase_q;
    dBase_d   = dBase_q;
    count_d   = count_q;
    idx_d     = idx_q;
    aReg_d    = aReg_q;
    bReg_d    = bReg_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          opLatch_d = op_i;
          aBase_d   = a_base_i;
          bBase_d   = b_base_i;
          dBase_d   = d_base_i;
          count_d   = count_i;
          idx_d     = '0;
          state_d   = (count_i == '0) ? S_DONE : S_RD_A;
        end
      end
      S_RD_A: state_d = S_RD_B;
      S_RD_B: begin
        aReg_d  = r_data_i;
        state_d = S_CAP_B;
      end
      S_CAP_B: begin
        bReg_d  = r_data_i;
        state_d = S_WR;
      end
      S_WR: begin
        // count_q is non-zero here, so count_q - 1 cannot underflow.
        if (idx_q == count_q - ADDR_W'(1)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = S_RD_A;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      opLatch_q <= '0;
      aBase_q   <= '0;
      bBase_q   <= '0;
      dBase_q   <= '0;
      count_q   <= '0;
      idx_q     <= '0;
      aReg_q    <= '0;
      bReg_q    <= '0;
    end else begin
      state_q   <= state_d;
      opLatch_q <= opLatch_d;
      aBase_q   <= aBase_d;
      bBase_q   <= bBase_d;
      dBase_q   <= dBase_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      aReg_q    <= aReg_d;
      bReg_q    <= bReg_d;
    end
  end

  // Outputs decode purely from the current state. Addresses and write data
  // are forced to zero outside the states that use them, so reset and idle
  // leave the RAM ports quiet. Address sums wrap modulo 2^ADDR_W.
  always_comb begin
    busy_o   = (state_q != S_IDLE);
    done_o   = (state_q == S_DONE);
    r_en_o   = 1'b0;
    r_addr_o = '0;
    w_en_o   = 1'b0;
    w_addr_o = '0;
    w_data_o = '0;
    case (state_q)
      S_RD_A: begin
        r_en_o   = 1'b1;
        r_addr_o = aBase_q + idx_q;
      end
      S_RD_B: begin
        r_en_o   = 1'b1;
        r_addr_o = bBase_q + idx_q;
      end
      S_WR: begin
        w_en_o   = 1'b1;
        w_addr_o = dBase_q + idx_q;
        w_data_o = alu_res_i;
      end
      default: ;
    endcase
  end

  assign alu_a_o  = aReg_q;
  assign alu_b_o  = bReg_q;
  assign alu_op_o = opLatch_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// tb_seq_ctrl: self-checking bench for seq_ctrl. It provides a 256-word
// synchronous RAM and a combinational ALU around the DUT.
//
// The reference model describes a command as a timeline. Element k is read in
// relative cycles 4k+1 and 4k+2 and written in cycle 4k+4, and done is high in
// cycle 4*count+1. Expected write data comes from a shadow copy of RAM that is
// updated in element order. A monitor compares every DUT output on every
// falling edge. Directed cases also pin literal RAM results and done timing.
module tb_seq_ctrl;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [4:0]    op = '0;
  logic [AW-1:0] aBase = '0, bBase = '0, dBase = '0, count = '0;

  logic          busy, done, rEn, wEn;
  logic [AW-1:0] rAddr, wAddr;
  logic [DW-1:0] rData, aluA, aluB, aluRes, wData;
  logic [4:0]    aluOp;

  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] expRam [DEPTH];
  logic          pokeEn = 1'b0;
  logic [AW-1:0] pokeAddr = '0;
  logic [DW-1:0] pokeData = '0;

  int checks = 0;
  int failures = 0;

  // Model state of the command currently in flight.
  bit        mActive = 1'b0;
  int        mN, mCnt, mA, mB, mD;
  logic [4:0] mOp;
  logic [4:0] lastOp = '0;

  always #5 clk = ~clk;

  seq_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op),
    .a_base_i(aBase), .b_base_i(bBase), .d_base_i(dBase), .count_i(count),
    .busy_o(busy), .done_o(done), .r_en_o(rEn), .r_addr_o(rAddr),
    .r_data_i(rData), .alu_a_o(aluA), .alu_b_o(aluB), .alu_op_o(aluOp),
    .alu_res_i(aluRes), .w_en_o(wEn), .w_addr_o(wAddr), .w_data_o(wData)
  );

  function automatic logic [DW-1:0] aluFn(input logic [4:0] o, input logic [DW-1:0] x, input logic [DW-1:0] y);
    case (o)
      5'd0: return x + y;
      5'd1: return x - y;
      5'd2: return x & y;
      5'd3: return x | y;
      5'd4: return x ^ y;
      default: return x ^ ~y;
    endcase
  endfunction

  always_comb aluRes = aluFn(aluOp, aluA, aluB);

  // Synchronous RAM. Bench preloads go through the poke port, so all RAM
  // writes happen in this one block.
  always @(posedge clk) begin
    if (pokeEn) ram[pokeAddr] <= pokeData;
    else if (wEn) ram[wAddr] <= wData;
    if (rEn) rData <= ram[rAddr];
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic monitor();
    bit isDone, isWr;
    int k, ph;
    logic eBusy, eDone, eREn, eWEn, chkAlu;
    logic [AW-1:0] eRAddr, eWAddr;
    logic [DW-1:0] eWData, eA, eB;
    forever begin
      @(negedge clk);
      eBusy = 0; eDone = 0; eREn = 0; eWEn = 0; chkAlu = 0;
      eRAddr = '0; eWAddr = '0; eWData = '0; eA = '0; eB = '0;
      isDone = 0; isWr = 0;
      if (!rst_n) begin
        mActive = 0;
        lastOp = '0;
        chkAlu = 1;
      end else if (mActive) begin
        eBusy = 1;
        if (mN == 4 * mCnt + 1) begin
          isDone = 1;
          eDone = 1;
        end else begin
          k = (mN - 1) / 4;
          ph = (mN - 1) % 4;
          if (ph == 0) begin eREn = 1; eRAddr = AW'((mA + k) % DEPTH); end
          if (ph == 1) begin eREn = 1; eRAddr = AW'((mB + k) % DEPTH); end
          if (ph == 3) begin
            isWr = 1;
            eA = expRam[(mA + k) % DEPTH];
            eB = expRam[(mB + k) % DEPTH];
            eWEn = 1;
            eWAddr = AW'((mD + k) % DEPTH);
            eWData = aluFn(mOp, eA, eB);
            chkAlu = 1;
          end
        end
      end
      checkOutput("busy", DW'(busy), DW'(eBusy));
      checkOutput("done", DW'(done), DW'(eDone));
      checkOutput("r_en", DW'(rEn), DW'(eREn));
      checkOutput("r_addr", DW'(rAddr), DW'(eRAddr));
      checkOutput("w_en", DW'(wEn), DW'(eWEn));
      checkOutput("w_addr", DW'(wAddr), DW'(eWAddr));
      checkOutput("w_data", wData, eWData);
      checkOutput("alu_op", DW'(aluOp), DW'(lastOp));
      if (chkAlu) begin
        checkOutput("alu_a", aluA, eA);
        checkOutput("alu_b", aluB, eB);
      end
      // Advance the model using the inputs the next rising edge will sample.
      if (rst_n) begin
        if (mActive) begin
          if (isWr) expRam[(mD + (mN - 1) / 4) % DEPTH] = eWData;
          if (isDone) mActive = 0;
          else mN++;
        end else if (start) begin
          mActive = 1;
          mN = 1;
          mCnt = int'(count);
          mA = int'(aBase); mB = int'(bBase); mD = int'(dBase);
          mOp = op;
          lastOp = op;
        end
      end
      if (pokeEn) expRam[pokeAddr] = pokeData;
    end
  endtask

  task automatic setRam(input int addr, input logic [DW-1:0] val);
    pokeEn = 1; pokeAddr = AW'(addr); pokeData = val;
    @(posedge clk); #1;
    pokeEn = 0;
  endtask

  // Issues one command and follows it until done, a reset abort, or the budget.
  task automatic applyStimulus(input logic [4:0] o, input int a, input int b, input int d, input int c,
                               input int restartAt, input int resetAt,
                               output int doneCyc, output int nWr, output int firstWr);
    int cyc;
    bit fin;
    op = o; aBase = AW'(a); bBase = AW'(b); dBase = AW'(d); count = AW'(c);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    op = 5'($urandom); aBase = AW'($urandom); bBase = AW'($urandom);
    dBase = AW'($urandom); count = AW'($urandom);
    cyc = 1; doneCyc = -1; nWr = 0; firstWr = -1; fin = 0;
    while (!fin && cyc <= 4 * c + 8) begin
      start = (cyc == restartAt);
      if (cyc == resetAt) rst_n = 0;
      @(negedge clk);
      if (wEn) begin
        nWr++;
        if (firstWr < 0) firstWr = cyc;
      end
      if (done) doneCyc = cyc;
      @(posedge clk); #1;
      if (resetAt > 0 && cyc == resetAt + 2) begin
        rst_n = 1;
        fin = 1;
      end
      if (doneCyc >= 0) fin = 1;
      cyc++;
    end
    start = 0;
  endtask

  task automatic stimulus();
    int dc, nw, fw, c, ra;
    #2 rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    // Empty command issued right as reset releases.
    applyStimulus(5'd0, 3, 4, 5, 0, 0, 0, dc, nw, fw);
    checkOutput("cnt0_done_cycle", DW'(dc), DW'(1));
    checkOutput("cnt0_writes", DW'(nw), DW'(0));

    for (int i = 0; i < DEPTH; i++) setRam(i, $urandom);

    // Single add: 5 + 7.
    setRam(0, 5); setRam(16, 7);
    applyStimulus(5'd0, 0, 16, 32, 1, 0, 0, dc, nw, fw);
    checkOutput("single_result", ram[32], 32'd12);
    checkOutput("single_done_cycle", DW'(dc), DW'(5));
    checkOutput("single_writes", DW'(nw), DW'(1));
    checkOutput("single_write_cycle", DW'(fw), DW'(4));

    // Four-element add, then the same command with a stray start in cycle 3.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        setRam(i, DW'(i + 1));
        setRam(8 + i, DW'(10 * (i + 1)));
        setRam(16 + i, 32'hdead);
      end
      applyStimulus(5'd0, 0, 8, 16, 4, (r == 1) ? 3 : 0, 0, dc, nw, fw);
      checkOutput("vec4_d0", ram[16], 32'd11);
      checkOutput("vec4_d1", ram[17], 32'd22);
      checkOutput("vec4_d2", ram[18], 32'd33);
      checkOutput("vec4_d3", ram[19], 32'd44);
      checkOutput("vec4_done_cycle", DW'(dc), DW'(17));
      checkOutput("vec4_writes", DW'(nw), DW'(4));
    end

    // Address wrap on reads and writes (in place at 254, 255, 0).
    setRam(254, 1); setRam(255, 2); setRam(0, 3);
    setRam(10, 10); setRam(11, 20); setRam(12, 30);
    applyStimulus(5'd0, 254, 10, 254, 3, 0, 0, dc, nw, fw);
    checkOutput("wrap_d254", ram[254], 32'd11);
    checkOutput("wrap_d255", ram[255], 32'd22);
    checkOutput("wrap_d0", ram[0], 32'd33);
    checkOutput("wrap_done_cycle", DW'(dc), DW'(13));

    // In-place add: D aliases A.
    setRam(0, 3); setRam(1, 4); setRam(8, 100); setRam(9, 200);
    applyStimulus(5'd0, 0, 8, 0, 2, 0, 0, dc, nw, fw);
    checkOutput("inplace_d0", ram[0], 32'd103);
    checkOutput("inplace_d1", ram[1], 32'd204);

    // Reset in cycle 6 of a three-element command: one write, no done.
    applyStimulus(5'd1, 40, 50, 60, 3, 0, 6, dc, nw, fw);
    checkOutput("abort_writes", DW'(nw), DW'(1));
    checkOutput("abort_no_done", DW'(dc), DW'(-1));

    // Randomized commands, some with a stray start mid-command.
    for (int t = 0; t < 16; t++) begin
      c = $urandom_range(0, 6);
      ra = (c > 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(2, 4 * c)) : 0;
      applyStimulus(5'($urandom_range(0, 7)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 255)), c, ra, 0, dc, nw, fw);
      checkOutput("rand_done_cycle", DW'(dc), DW'(4 * c + 1));
      checkOutput("rand_writes", DW'(nw), DW'(c));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (2) @(posedge clk);
    for (int i = 0; i < DEPTH; i++) checkOutput("ram_final", ram[i], expRam[i]);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
    disable fork;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_ctrl.md
SEQ_CTRL -- requirements
Module: seq_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, ALU operand, result and RAM word width.
REQ-002 Parameter ADDR_W, default 8, RAM address width; also the width of count.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  command strobe; sampled only in IDLE.
REQ-006 op_in  in  5  ALU opcode for the command.
REQ-007 a_base, b_base, d_base  in  ADDR_W  base addresses of operand vector A, operand vector B and destination vector D.
REQ-008 count  in  ADDR_W  number of elements, 0..2^ADDR_W-1.
REQ-009 busy  out  1  high while a command is in progress (any state except IDLE).
REQ-010 done  out  1  one-cycle pulse when a command completes.
REQ-011 r_en  out  1, r_addr  out  ADDR_W  RAM read port; synchronous read, r_data is valid the cycle after r_en.
REQ-012 r_data  in  DATA_W  RAM read data.
REQ-013 alu_a, alu_b  out  DATA_W, alu_op  out  5  ALU operands and opcode; the ALU is combinational.
REQ-014 alu_res  in  DATA_W  ALU result.
REQ-015 w_en  out  1, w_addr  out  ADDR_W, w_data  out  DATA_W  RAM write port; written on the clk edge while w_en is high.

Function
REQ-016 On start in IDLE, seq_ctrl SHALL latch op_in, a_base, b_base, d_base and count; later input changes have no effect on that command.
REQ-017 start while busy SHALL be ignored, with no queuing.
REQ-018 States: IDLE, RD_A, RD_B, CAP_B, WR, DONE.
REQ-019 IDLE SHALL go to RD_A on start with count!=0, and directly to DONE on start with count==0.
REQ-020 RD_A SHALL drive r_en=1, r_addr=a_base+i, then go to RD_B.
REQ-021 RD_B SHALL drive r_en=1, r_addr=b_base+i, capture r_data into a_reg, then go to CAP_B.
REQ-022 CAP_B SHALL capture r_data into b_reg and go to WR; r_en=0.
REQ-023 WR SHALL drive w_en=1, w_addr=d_base+i, w_data=alu_res.
REQ-024 In WR, when i==count-1 the FSM SHALL go to DONE; otherwise it SHALL increment i and return to RD_A.
REQ-025 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-026 alu_a=a_reg, alu_b=b_reg and alu_op=latched op at all times.
REQ-027 i is the element index, cleared on an accepted start.
REQ-028 Address sums SHALL be computed modulo 2^ADDR_W and wrap silently.
REQ-029 Timing: start sampled at edge 0; element k has RD_A in cycle 4k+1 and WR in cycle 4k+4; done is high in cycle 4*count+1; busy is high in cycles 1..4*count+1.
REQ-030 r_en and w_en SHALL never both be high in the same cycle, and SHALL both be 0 in IDLE and DONE.
REQ-031 Elements SHALL be processed strictly in order, with a write before the next read, so an overlapping or in-place D (d_base==a_base) gives sequential-loop semantics.
REQ-032 count==0 SHALL produce no RAM access and a done pulse in cycle 1.

Reset
REQ-033 While rst=0, state SHALL be IDLE and busy=0, done=0, r_en=0, w_en=0; r_addr, w_addr and i SHALL be 0; a_reg, b_reg, w_data, alu_a and alu_b SHALL be 0; alu_op SHALL be 0.
REQ-034 Reset asserted mid-command SHALL abort the command immediately with no further write and no done pulse; RAM contents already written are kept.
REQ-035 After rst deasserts, the first start SHALL be accepted at the next rising edge.

Verification
REQ-036 RAM[0]=5, RAM[16]=7, op=add, a=0, b=16, d=32, count=1, start -> RAM[32]=12, w_en only in cycle 4, done in cycle 5.
REQ-037 count=4, a=0, b=8, d=16, A=1..4, B=10..40 -> RAM[16..19]=11,22,33,44; 16 active cycles; done in cycle 17.
REQ-038 a_base=254, count=3 -> reads at addresses 254, 255, 0; writes wrap the same way.
REQ-039 count=0, start -> done in cycle 1; r_en and w_en stay 0.
REQ-040 start pulsed again in cycle 3 of a running command -> ignored, with identical results and timing; reset in cycle 6 of a count=3 command -> exactly 1 write performed, then no done and all outputs return to reset values.
REQ-041 In-place d=a=0, b=8, op=add, count=2 -> RAM[0]=A0+B0 and RAM[1]=A1+B1, with no stale data used.
